// File: rtl/regbank_access_sequencer_pkg.sv
// Shared definitions for the register-bank access sequencer: default widths and FSM states.
package regbank_access_sequencer_pkg;

    localparam int unsigned DefaultDataWidth    = 32;
    localparam int unsigned DefaultRegAddrWidth = 4;
    localparam logic [DefaultRegAddrWidth-1:0] RegZero = '0;

    typedef enum logic [2:0] {
        StIdle,
        StReadA,
        StReadB,
        StHold,
        StWrite
    } seq_state_e;

endpackage

// File: rtl/regbank_access_sequencer_if.sv
// Bundles the decode read request, operand hand-off, writeback and bank port signals.
interface regbank_access_sequencer_if
    import regbank_access_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DefaultDataWidth,
    parameter int unsigned REG_ADDR_WIDTH = DefaultRegAddrWidth
) ();

    logic                      rd_req_valid;
    logic                      rd_req_ready;
    logic [REG_ADDR_WIDTH-1:0] rd_req_rs1;
    logic [REG_ADDR_WIDTH-1:0] rd_req_rs2;

    logic                      op_valid;
    logic                      op_ready;
    logic [DATA_WIDTH-1:0]     op_a;
    logic [DATA_WIDTH-1:0]     op_b;

    logic                      wb_valid;
    logic                      wb_ready;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]     wb_data;

    logic [REG_ADDR_WIDTH-1:0] bank_reg_num;
    logic [DATA_WIDTH-1:0]     bank_data_in;
    logic                      bank_write_enable;
    logic [DATA_WIDTH-1:0]     bank_data_out;

    // Requester side: decode, execute, writeback and the register bank itself.
    modport master (
        output rd_req_valid, rd_req_rs1, rd_req_rs2, op_ready, wb_valid, wb_rd, wb_data,
               bank_data_out,
        input  rd_req_ready, op_valid, op_a, op_b, wb_ready, bank_reg_num, bank_data_in,
               bank_write_enable
    );

    modport slave (
        input  rd_req_valid, rd_req_rs1, rd_req_rs2, op_ready, wb_valid, wb_rd, wb_data,
               bank_data_out,
        output rd_req_ready, op_valid, op_a, op_b, wb_ready, bank_reg_num, bank_data_in,
               bank_write_enable
    );

endinterface

// File: rtl/regbank_access_sequencer.sv
// Sole owner of the single-port register bank: serialises operand reads and writebacks.
module regbank_access_sequencer
    import regbank_access_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DefaultDataWidth,
    parameter int unsigned REG_ADDR_WIDTH = DefaultRegAddrWidth
) (
    input  logic                       clk,
    input  logic                       rst_n,
    regbank_access_sequencer_if.slave  bus,
    output logic                       busy_o
);

    seq_state_e                state_q;
    logic [REG_ADDR_WIDTH-1:0] rs1_q;
    logic [REG_ADDR_WIDTH-1:0] rs2_q;
    logic [REG_ADDR_WIDTH-1:0] reg_num_q;
    logic [DATA_WIDTH-1:0]     data_in_q;
    logic                      write_en_q;
    logic [DATA_WIDTH-1:0]     op_a_q;
    logic [DATA_WIDTH-1:0]     op_b_q;
    logic                      op_valid_q;

    // Bank address/data registers double as the latched rd/data of a pending writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rs1_q      <= '0;
            rs2_q      <= '0;
            reg_num_q  <= '0;
            data_in_q  <= '0;
            write_en_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.wb_valid) begin
                        reg_num_q  <= bus.wb_rd;
                        data_in_q  <= bus.wb_data;
                        write_en_q <= (bus.wb_rd != REG_ADDR_WIDTH'(RegZero));
                        state_q    <= StWrite;
                    end else if (bus.rd_req_valid) begin
                        rs1_q     <= bus.rd_req_rs1;
                        rs2_q     <= bus.rd_req_rs2;
                        reg_num_q <= bus.rd_req_rs1;
                        state_q   <= StReadA;
                    end
                end
                StReadA: begin
                    op_a_q <= bus.bank_data_out;
                    if (rs2_q == rs1_q) begin
                        op_b_q     <= bus.bank_data_out;
                        op_valid_q <= 1'b1;
                        reg_num_q  <= '0;
                        state_q    <= StHold;
                    end else begin
                        reg_num_q <= rs2_q;
                        state_q   <= StReadB;
                    end
                end
                StReadB: begin
                    op_b_q     <= bus.bank_data_out;
                    op_valid_q <= 1'b1;
                    reg_num_q  <= '0;
                    state_q    <= StHold;
                end
                StHold: begin
                    if (bus.op_ready) begin
                        op_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                StWrite: begin
                    reg_num_q  <= '0;
                    data_in_q  <= '0;
                    write_en_q <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Writeback has priority over a same-cycle read request.
    assign bus.wb_ready     = rst_n && (state_q == StIdle);
    assign bus.rd_req_ready = rst_n && (state_q == StIdle) && !bus.wb_valid;

    assign bus.op_valid          = op_valid_q;
    assign bus.op_a              = op_a_q;
    assign bus.op_b              = op_b_q;
    assign bus.bank_reg_num      = reg_num_q;
    assign bus.bank_data_in      = data_in_q;
    assign bus.bank_write_enable = write_en_q;
    assign busy_o                = (state_q != StIdle);

endmodule

// File: tb/tb_regbank_access_sequencer.sv
// Sequencer plus a behavioural register bank, checked against a transaction-level register model.
module tb_regbank_access_sequencer;
    import regbank_access_sequencer_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned RAW = 4;
    localparam int unsigned NR  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bank_rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    regbank_access_sequencer_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW)) bus ();

    regbank_access_sequencer #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy_o (busy)
    );

    // Register bank: own reset, sync write, combinational read; x0 is not protected here.
    logic [DW-1:0] bank_mem [NR];
    always_ff @(posedge clk or negedge bank_rst_n) begin
        if (!bank_rst_n) begin
            for (int i = 0; i < NR; i++) bank_mem[i] <= '0;
        end else if (bus.bank_write_enable) begin
            bank_mem[bus.bank_reg_num] <= bus.bank_data_in;
        end
    end
    assign bus.bank_data_out = bank_mem[bus.bank_reg_num];

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;
    logic [DW-1:0] ref_regs [NR];

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [RAW-1:0] rd, input logic [DW-1:0] data);
        @(negedge clk);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = data;
        #1;
        check_eq("wb_ready_idle", DW'(bus.wb_ready), DW'(1));
        @(negedge clk);
        bus.wb_valid = 1'b0;
        check_eq("wr_we", DW'(bus.bank_write_enable), DW'(rd != 0));
        check_eq("wr_reg_num", DW'(bus.bank_reg_num), DW'(rd));
        check_eq("wr_data_in", bus.bank_data_in, data);
        if (rd != 0) ref_regs[rd] = data;
        @(negedge clk);
        check_eq("wr_done_busy", DW'(busy), DW'(0));
        check_eq("wr_done_we", DW'(bus.bank_write_enable), DW'(0));
    endtask

    // Entered at the negedge right after the accepting edge.
    task automatic wait_operands(input logic [RAW-1:0] rs1, input logic [RAW-1:0] rs2,
                                 input int unsigned hold);
        int unsigned   lat;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        exp_a = ref_regs[rs1];
        exp_b = ref_regs[rs2];
        lat = 0;
        check_eq("rda_reg_num", DW'(bus.bank_reg_num), DW'(rs1));
        while (!bus.op_valid && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        check_eq("rd_latency", DW'(lat), DW'((rs1 == rs2) ? 1 : 2));
        check_eq("op_a", bus.op_a, exp_a);
        check_eq("op_b", bus.op_b, exp_b);
        check_eq("hold_reg_num", DW'(bus.bank_reg_num), DW'(0));
        for (int h = 0; h < int'(hold); h++) begin
            bus.op_ready = 1'b0;
            bus.wb_valid = 1'b1;
            bus.wb_rd    = RAW'($urandom_range(1, NR - 1));
            bus.wb_data  = $urandom;
            #1;
            check_eq("hold_wb_ready", DW'(bus.wb_ready), DW'(0));
            check_eq("hold_rd_ready", DW'(bus.rd_req_ready), DW'(0));
            @(negedge clk);
            check_eq("hold_valid", DW'(bus.op_valid), DW'(1));
            check_eq("hold_a", bus.op_a, exp_a);
            check_eq("hold_b", bus.op_b, exp_b);
        end
        bus.wb_valid = 1'b0;
        bus.op_ready = 1'b1;
        @(negedge clk);
        bus.op_ready = 1'b0;
        check_eq("release_valid", DW'(bus.op_valid), DW'(0));
        check_eq("release_busy", DW'(busy), DW'(0));
    endtask

    task automatic issue_read(input logic [RAW-1:0] rs1, input logic [RAW-1:0] rs2,
                              input int unsigned hold);
        @(negedge clk);
        bus.rd_req_valid = 1'b1;
        bus.rd_req_rs1   = rs1;
        bus.rd_req_rs2   = rs2;
        #1;
        check_eq("rd_req_ready", DW'(bus.rd_req_ready), DW'(1));
        @(negedge clk);
        bus.rd_req_valid = 1'b0;
        wait_operands(rs1, rs2, hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RAW-1:0] r1;
        logic [RAW-1:0] r2;
        for (int i = 0; i < NR; i++) ref_regs[i] = '0;
        bus.rd_req_valid = 1'b0;
        bus.rd_req_rs1   = '0;
        bus.rd_req_rs2   = '0;
        bus.op_ready     = 1'b0;
        bus.wb_valid     = 1'b0;
        bus.wb_rd        = '0;
        bus.wb_data      = '0;

        #12;
        check_eq("rst_op_valid", DW'(bus.op_valid), DW'(0));
        check_eq("rst_busy", DW'(busy), DW'(0));
        check_eq("rst_we", DW'(bus.bank_write_enable), DW'(0));
        check_eq("rst_rd_ready", DW'(bus.rd_req_ready), DW'(0));
        check_eq("rst_op_a", bus.op_a, '0);
        @(negedge clk);
        rst_n      = 1'b1;
        bank_rst_n = 1'b1;
        #1;
        check_eq("idle_rd_ready", DW'(bus.rd_req_ready), DW'(1));
        check_eq("idle_wb_ready", DW'(bus.wb_ready), DW'(1));

        do_write(RAW'(5), 32'hDEAD_BEEF);
        issue_read(RAW'(5), RAW'(0), 0);

        // Same-cycle conflict: writeback first, then the read sees the new value.
        @(negedge clk);
        bus.wb_valid     = 1'b1;
        bus.wb_rd        = RAW'(3);
        bus.wb_data      = 32'h11;
        bus.rd_req_valid = 1'b1;
        bus.rd_req_rs1   = RAW'(3);
        bus.rd_req_rs2   = RAW'(4);
        #1;
        check_eq("conf_wb_ready", DW'(bus.wb_ready), DW'(1));
        check_eq("conf_rd_ready", DW'(bus.rd_req_ready), DW'(0));
        ref_regs[3] = 32'h11;
        @(negedge clk);
        bus.wb_valid = 1'b0;
        check_eq("conf_wr_rd_ready", DW'(bus.rd_req_ready), DW'(0));
        @(negedge clk);
        #1;
        check_eq("conf_rd_ready2", DW'(bus.rd_req_ready), DW'(1));
        @(negedge clk);
        bus.rd_req_valid = 1'b0;
        wait_operands(RAW'(3), RAW'(4), 0);

        do_write(RAW'(7), 32'hA5);
        issue_read(RAW'(7), RAW'(7), 0);

        do_write(RAW'(8), 32'h1234_5678);
        issue_read(RAW'(8), RAW'(7), 10);

        do_write(RAW'(0), 32'hFFFF);
        issue_read(RAW'(0), RAW'(5), 1);

        // Reset while in READ_B discards the read immediately.
        do_write(RAW'(9), 32'h0BAD_F00D);
        @(negedge clk);
        bus.rd_req_valid = 1'b1;
        bus.rd_req_rs1   = RAW'(9);
        bus.rd_req_rs2   = RAW'(5);
        @(negedge clk);
        bus.rd_req_valid = 1'b0;
        @(negedge clk);
        check_eq("rdb_reg_num", DW'(bus.bank_reg_num), DW'(5));
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", DW'(bus.op_valid), DW'(0));
        check_eq("midrst_busy", DW'(busy), DW'(0));
        check_eq("midrst_reg_num", DW'(bus.bank_reg_num), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during WRITE abandons the write; the bank keeps the old value.
        @(negedge clk);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = RAW'(9);
        bus.wb_data  = 32'hCAFE_0000;
        @(negedge clk);
        bus.wb_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("wrrst_we", DW'(bus.bank_write_enable), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        issue_read(RAW'(9), RAW'(9), 0);

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_write(RAW'($urandom_range(0, NR - 1)), $urandom);
            end else begin
                r1 = RAW'($urandom_range(0, NR - 1));
                r2 = ($urandom_range(0, 3) == 0) ? r1 : RAW'($urandom_range(0, NR - 1));
                issue_read(r1, r2, $urandom_range(0, 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
